// File: rtl/lab3_d_ff_gatelevel_pkg.sv
// Shared constants for the gate-level master-slave D flip-flop.
`timescale 1ns/1ps
package lab3_d_ff_gatelevel_pkg;

    localparam int DEFAULT_WIDTH = 1;

endpackage

// File: rtl/d_latch_gatelevel.sv
// Gated SR-NAND D latch: transparent while En=1, holds while En=0.
`timescale 1ns/1ps
module d_latch_gatelevel (
    input  logic En,
    input  logic D,
    output wire  Q,
    output wire  Qb
);

    wire d_n;
    wire s_n;
    wire r_n;

    not  u_inv (d_n, D);
    nand u_set (s_n, D, En);
    nand u_rst (r_n, d_n, En);

    // Cross-coupled pair is the storage element.
    nand u_q   (Q, s_n, Qb);
    nand u_qb  (Qb, r_n, Q);

endmodule

// File: rtl/lab3_d_ff_gatelevel.sv
// Positive-edge D flip-flop per bit: master latch on ~Clk feeding slave latch on Clk,
// with a synchronous active-high reset folded into the data path.
`timescale 1ns/1ps
module lab3_d_ff_gatelevel
    import lab3_d_ff_gatelevel_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] D,
    output wire  [WIDTH-1:0] Q,
    output wire  [WIDTH-1:0] Qb
);

    wire             clk_n;
    wire             rst_n;
    wire [WIDTH-1:0] dg;
    wire [WIDTH-1:0] mq;
    // The slave only needs the master's true output.
    wire [WIDTH-1:0] master_qb_unused;

    not u_clk_inv (clk_n, Clk);
    not u_rst_inv (rst_n, Rst);

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            // Reset wins over data because it is gated in before the master samples.
            and u_gate (dg[i], D[i], rst_n);

            d_latch_gatelevel u_master (
                .En (clk_n),
                .D  (dg[i]),
                .Q  (mq[i]),
                .Qb (master_qb_unused[i])
            );

            d_latch_gatelevel u_slave (
                .En (Clk),
                .D  (mq[i]),
                .Q  (Q[i]),
                .Qb (Qb[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_lab3_d_ff_gatelevel.sv
// Bench for lab3_d_ff_gatelevel: directed timeline plus randomized cycles on 1- and 4-bit instances.
`timescale 1ns/1ps
module tb_lab3_d_ff_gatelevel;

  logic       Clk;
  logic       Rst;
  logic       D1;
  logic [3:0] D4;
  logic       Q1;
  logic       Qb1;
  logic [3:0] Q4;
  logic [3:0] Qb4;

  int vectors;
  int miscompares;

  logic       exp1;
  logic [3:0] exp4;
  logic       have_exp;

  lab3_d_ff_gatelevel #(.WIDTH(1)) dut1 (
    .Clk (Clk),
    .Rst (Rst),
    .D   (D1),
    .Q   (Q1),
    .Qb  (Qb1)
  );

  lab3_d_ff_gatelevel #(.WIDTH(4)) dut4 (
    .Clk (Clk),
    .Rst (Rst),
    .D   (D4),
    .Q   (Q4),
    .Qb  (Qb4)
  );

  // clock: rises at 5, 15, 25 ...
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, got, want);
    end
  endtask

  task automatic compare_all(input string phase);
    if (have_exp) begin
      check({phase, "_q1"},  {3'b000, Q1},  {3'b000, exp1});
      check({phase, "_qb1"}, {3'b000, Qb1}, {3'b000, !exp1});
      check({phase, "_q4"},  Q4,  exp4);
      check({phase, "_qb4"}, Qb4, ~exp4);
    end
  endtask

  task automatic wait_until(input int t);
    #(t - int'($time));
  endtask

  // reference model: each rising edge stores the pre-edge data, or zero under reset
  always @(posedge Clk) begin
    exp1     = Rst ? 1'b0 : D1;
    exp4     = Rst ? 4'b0000 : D4;
    have_exp = 1'b1;
  end

  // compare just after each edge and just before the next rising edge
  always @(posedge Clk) begin
    #1 compare_all("post_rise");
  end

  always @(negedge Clk) begin
    #1 compare_all("post_fall");
    #3 compare_all("pre_rise");
  end

  // outputs may only move at a rising edge
  always @(Q1 or Q4) begin
    if (have_exp) begin
      vectors++;
      if (($time % 10) != 5) begin
        miscompares++;
        $display("FAIL q_change_off_edge at %0t: got change at t mod 10 = %0d, expected 5",
                 $time, $time % 10);
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    have_exp    = 1'b0;
    exp1        = 1'b0;
    exp4        = 4'b0000;
    Rst         = 1'b0;
    D1          = 1'b0;
    D4          = 4'b0000;

    // basic capture
    wait_until(7);   D1 = 1'b1;
    wait_until(16);  check("basic_q_16", {3'b000, Q1}, 4'd1);
                     check("basic_qb_16", {3'b000, Qb1}, 4'd0);
    wait_until(17);  D1 = 1'b0;
    wait_until(26);  check("basic_q_26", {3'b000, Q1}, 4'd0);

    // changes while Clk high are ignored
    wait_until(37);  D1 = 1'b1;
    wait_until(44);  check("midhigh_q_44", {3'b000, Q1}, 4'd0);
    wait_until(47);  D1 = 1'b0;
    wait_until(50);  check("midhigh_q_50", {3'b000, Q1}, 4'd1);
    wait_until(56);  check("midhigh_q_56", {3'b000, Q1}, 4'd0);

    // glitch rejection
    wait_until(57);  D1 = 1'b1;
    wait_until(66);  check("glitch_q_66", {3'b000, Q1}, 4'd1);
    wait_until(77);  D1 = 1'b0;
    wait_until(81);  D1 = 1'b1;
    wait_until(86);  check("glitch_q_86", {3'b000, Q1}, 4'd1);

    // falling-edge immunity
    wait_until(89);  D1 = 1'b0;
    wait_until(96);  check("fall_q_96", {3'b000, Q1}, 4'd0);
    wait_until(99);  D1 = 1'b1;
    wait_until(101); check("fall_q_101", {3'b000, Q1}, 4'd0);
    wait_until(106); check("fall_q_106", {3'b000, Q1}, 4'd1);

    // synchronous reset with D held at 1
    wait_until(162); Rst = 1'b1;
    wait_until(164); check("rst_q_164", {3'b000, Q1}, 4'd1);
    wait_until(166); check("rst_q_166", {3'b000, Q1}, 4'd0);
                     check("rst_qb_166", {3'b000, Qb1}, 4'd1);
    wait_until(167); Rst = 1'b0;

    // multi-bit capture then reset
    wait_until(171); D4 = 4'b1010;
    wait_until(176); check("rst_q_176", {3'b000, Q1}, 4'd1);
                     check("wide_q_176", Q4, 4'b1010);
                     check("wide_qb_176", Qb4, 4'b0101);
    wait_until(177); Rst = 1'b1;
    wait_until(186); check("wide_q_186", Q4, 4'b0000);
                     check("wide_qb_186", Qb4, 4'b1111);
                     check("rst_q_186", {3'b000, Q1}, 4'd0);
    wait_until(187); Rst = 1'b0;

    // randomized cycles: noise in the high phase, a settle value (and maybe a second one) in the low phase
    wait_until(197);
    for (int c = 0; c < 300; c++) begin
      D1 = 1'($urandom_range(0, 1));
      D4 = 4'($urandom_range(0, 15));
      #4;
      D1  = 1'($urandom_range(0, 1));
      D4  = 4'($urandom_range(0, 15));
      Rst = ($urandom_range(0, 4) == 0);
      #2;
      if ($urandom_range(0, 1) == 1) begin
        D1 = 1'($urandom_range(0, 1));
        D4 = 4'($urandom_range(0, 15));
      end
      #4;
    end

    #20;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
